// File: rtl/tx_byte_serializer.sv
// tx_byte_serializer
//   Accepts bytes over a valid/ready handshake into a one-byte holding
//   register and shifts each out as an async-serial frame:
//   start(0), 8 data bits LSB-first, [even parity], stop(1).
//   A second byte may be accepted while a frame is on the line; it is moved
//   into the shift register on the last stop-bit cycle so that frames run
//   back to back with no idle gap.
//
// Optional feature macro: PARITY_EN -- inserts an even parity bit between
//   the data and stop bits (11-bit frames instead of 10).
//
// Parameters
//   CLK_DIV     sysclk cycles per serial bit (2..65535)
// Ports
//   sysclk      system clock, rising edge
//   reset       asynchronous active-low reset
//   data_in     byte to transmit, sampled on accept
//   data_valid  source has a byte on data_in
//   data_ready  holding register empty (accept = data_valid & data_ready)
//   tx_bit      registered serial line, idles high
//   bit_strobe  one-cycle pulse on the first cycle of every frame bit
//   busy        high whenever a frame is in progress
//   frame_done  one-cycle pulse on the last cycle of the stop bit
module tx_byte_serializer #(
  parameter int CLK_DIV = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_bit,
  output logic       bit_strobe,
  output logic       busy,
  output logic       frame_done
);

  localparam int            TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bcnt, bcnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    hold;
  logic          hold_full;
  logic          tx_nxt;
  logic          bit_end;
  logic          load;
  logic          accept;
`ifdef PARITY_EN
  logic          par;
`endif

  assign bit_end = (timer == T_LAST);
  assign accept  = data_valid && !hold_full;
  // Holding -> shift transfer; only possible while holding is full, so it
  // can never coincide with an accept.
  assign load    = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));

  // State and datapath registers
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      bcnt      <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_bit    <= 1'b1;
`ifdef PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      bcnt   <= bcnt_nxt;
      shift  <= shift_nxt;
      tx_bit <= tx_nxt;
      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
`ifdef PARITY_EN
      if (load) par <= ^hold;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    timer_nxt = (state == IDLE || bit_end) ? '0 : timer + TW'(1);
    bcnt_nxt  = bcnt;
    shift_nxt = shift;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_nxt = START;
          shift_nxt = hold;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bcnt_nxt  = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift[7:1]};
          bcnt_nxt  = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
`ifdef PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (hold_full) begin
            state_nxt = START;
            shift_nxt = hold;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: tx_bit is registered from the next-state view so the line
  // changes exactly on the bit boundary; the rest decode current state.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[0];
`ifdef PARITY_EN
      PARITY: tx_nxt = par;
`endif
      default: tx_nxt = 1'b1;
    endcase
    busy       = (state != IDLE);
    bit_strobe = (state != IDLE) && (timer == '0);
    frame_done = (state == STOP) && bit_end;
    data_ready = !hold_full;
  end

endmodule

// File: tb/tb_tx_byte_serializer.sv
// Self-checking bench for tx_byte_serializer with CLK_DIV=4.
// A frame-level model (accept times, frame start times, frame bit function)
// predicts every output on every cycle; captured frames are also compared
// against hand-computed literal bit patterns.
module tb_tx_byte_serializer;
  localparam int D = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] LIT69 = 11'h4D2;
  localparam logic [10:0] LITEF = 11'h7DE;
  localparam logic [10:0] LIT55 = 11'h4AA;
`else
  localparam int NB = 10;
  localparam logic [10:0] LIT69 = 11'h2D2;
  localparam logic [10:0] LITEF = 11'h3DE;
  localparam logic [10:0] LIT55 = 11'h2AA;
`endif
  localparam int FL = NB * D;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, tx_bit, bit_strobe, busy, frame_done;

  always #5 sysclk = ~sysclk;

  tx_byte_serializer #(.CLK_DIV(D)) dut (
    .sysclk(sysclk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx_bit(tx_bit), .bit_strobe(bit_strobe),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct { int acc; int start; logic [7:0] b; } frm_t;
  typedef struct { logic [10:0] bits; int nstb; int first; int last; } cap_t;
  frm_t mq[$];
  cap_t caps[$];
  logic [10:0] cur_bits;
  int cur_n, cur_first, cyc, n_chk, n_fail, n_done, waited;

  function automatic logic frame_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-level model
  task automatic cycle_check();
    logic etx, estb, edone, ebusy, erdy;
    int off;
    etx = 1'b1; estb = 1'b0; edone = 1'b0; ebusy = 1'b0; erdy = 1'b1;
    if (reset) begin
      foreach (mq[i]) begin
        if (cyc >= mq[i].acc && cyc < mq[i].start) erdy = 1'b0;
        if (cyc >= mq[i].start && cyc < mq[i].start + FL) begin
          off   = cyc - mq[i].start;
          ebusy = 1'b1;
          etx   = frame_bit(mq[i].b, off / D);
          estb  = (off % D == 0);
          edone = (off == FL - 1);
        end
      end
    end
    check("tx_bit", tx_bit, etx);
    check("bit_strobe", bit_strobe, estb);
    check("frame_done", frame_done, edone);
    check("busy", busy, ebusy);
    check("data_ready", data_ready, erdy);
  endtask

  // One clock: compare/capture/record at negedge, return at posedge+1
  task automatic tick();
    int st;
    @(negedge sysclk);
    cycle_check();
    if (reset) begin
      if (bit_strobe) begin
        if (cur_n == 0) cur_first = cyc;
        if (cur_n < 11) cur_bits[cur_n] = tx_bit;
        cur_n++;
      end
      if (frame_done) begin
        n_done++;
        caps.push_back('{cur_bits, cur_n, cur_first, cyc});
        cur_n = 0;
        cur_bits = '0;
      end
      if (data_valid && data_ready) begin
        st = cyc + 2;
        if (mq.size() > 0 && mq[$].start + FL > st) st = mq[$].start + FL;
        mq.push_back('{cyc + 1, st, data_in});
      end
    end
    @(posedge sysclk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int w);
    data_in = b;
    data_valid = 1'b1;
    w = 0;
    while (!data_ready && w < 200) begin
      tick();
      w++;
    end
    if (!data_ready) check("send_timeout", 0, 1);
    else tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (caps.size() < n && k < 400) begin
      tick();
      k++;
    end
    check("frame_timeout", caps.size() >= n, 1);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    mq.delete();
    cur_n = 0;
    cur_bits = '0;
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; n_done = 0; cur_n = 0; cur_first = 0;
    cur_bits = '0;
    reset = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h69;
    @(posedge sysclk); #1;
    repeat (3) tick();
    check("rst_tx", tx_bit, 1);
    check("rst_ready", data_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_strobe", bit_strobe, 0);

    // Release with data_valid held: accepted on the first edge
    reset = 1'b1;
    send(8'h69, waited);
    check("acc_wait", waited, 0);
    check("acc_ready", data_ready, 0);
    check("acc_busy", busy, 0);
    tick();
    check("start_tx", tx_bit, 0);
    check("start_strobe", bit_strobe, 1);
    check("start_busy", busy, 1);
    check("start_ready", data_ready, 1);
    wait_frames(1);
    check("f0_bits", caps[0].bits, LIT69);
    check("f0_strobes", caps[0].nstb, NB);
    check("f0_len", caps[0].last - caps[0].first + 1, FL);
    check("f0_done_cnt", n_done, 1);

    // 0xEF
    repeat (3) tick();
    send(8'hEF, waited);
    wait_frames(2);
    check("f1_bits", caps[1].bits, LITEF);
    check("f1_strobes", caps[1].nstb, NB);

    // Back-to-back 0x69, 0xEF
    repeat (2) tick();
    send(8'h69, waited);
    send(8'hEF, waited);
    wait_frames(4);
    check("b2b_f0", caps[2].bits, LIT69);
    check("b2b_f1", caps[3].bits, LITEF);
    check("b2b_gap", caps[3].first, caps[2].last + 1);
    check("b2b_len", caps[3].last - caps[2].first + 1, 2 * FL);

    // Stall: 0x55 offered while holding is full
    repeat (2) tick();
    send(8'h69, waited);
    send(8'hEF, waited);
    send(8'h55, waited);
    check("stall_wait", waited, FL - 1);
    wait_frames(7);
    check("stall_f0", caps[4].bits, LIT69);
    check("stall_f1", caps[5].bits, LITEF);
    check("stall_f2", caps[6].bits, LIT55);

    // Reset during data bit 3 of 0x69 with 0xEF held
    repeat (2) tick();
    send(8'h69, waited);
    send(8'hEF, waited);
    repeat (15) tick();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ready", data_ready, 0);
    assert_reset();
    #1;
    check("mid_rst_tx", tx_bit, 1);
    check("mid_rst_ready", data_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobe", bit_strobe, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    send(8'h55, waited);
    wait_frames(8);
    check("fresh_bits", caps[7].bits, LIT55);
    check("fresh_strobes", caps[7].nstb, NB);
    repeat (FL + 5) tick();
    check("no_stale_frame", caps.size(), 8);
    check("done_total", n_done, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
